// File: rtl/display_notes.sv
// Switch-code to tone-divider lookup with registered note status.
// Optional build macro DISPLAY_NOTES_HALF_PERIOD_EN selects half-period divider counts.
module display_notes #(
  parameter int unsigned CLK_FREQ = 32'd50_000_000,
  parameter int unsigned F_DO1    = 32'd523,
  parameter int unsigned F_RE     = 32'd587,
  parameter int unsigned F_MI     = 32'd659,
  parameter int unsigned F_FA     = 32'd698,
  parameter int unsigned F_SOL    = 32'd783,
  parameter int unsigned F_LA     = 32'd880,
  parameter int unsigned F_SI     = 32'd987,
  parameter int unsigned F_DO2    = 32'd1046
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  sw,
  output logic [31:0] out,
  output logic        note_valid,
  output logic [2:0]  note_idx
);

`ifdef DISPLAY_NOTES_HALF_PERIOD_EN
  localparam int unsigned DIV_SHIFT = 32'd1;
`else
  localparam int unsigned DIV_SHIFT = 32'd0;
`endif

  // Divisors are fixed at elaboration; truncating integer division matches the tone generator.
  localparam logic [31:0] DIV_DO1 = 32'(CLK_FREQ / F_DO1) >> DIV_SHIFT;
  localparam logic [31:0] DIV_RE  = 32'(CLK_FREQ / F_RE)  >> DIV_SHIFT;
  localparam logic [31:0] DIV_MI  = 32'(CLK_FREQ / F_MI)  >> DIV_SHIFT;
  localparam logic [31:0] DIV_FA  = 32'(CLK_FREQ / F_FA)  >> DIV_SHIFT;
  localparam logic [31:0] DIV_SOL = 32'(CLK_FREQ / F_SOL) >> DIV_SHIFT;
  localparam logic [31:0] DIV_LA  = 32'(CLK_FREQ / F_LA)  >> DIV_SHIFT;
  localparam logic [31:0] DIV_SI  = 32'(CLK_FREQ / F_SI)  >> DIV_SHIFT;
  localparam logic [31:0] DIV_DO2 = 32'(CLK_FREQ / F_DO2) >> DIV_SHIFT;

  logic [31:0] out_s;
  logic        valid_s;
  logic [2:0]  idx_s;
  logic [31:0] out_r;
  logic        valid_r;
  logic [2:0]  idx_r;

  // Decode the switch code; every unlisted code (including all even codes) is silence.
  always_comb begin
    out_s   = 32'd0;
    valid_s = 1'b0;
    idx_s   = 3'd0;
    case (sw)
      4'b0001: begin out_s = DIV_DO1; valid_s = 1'b1; idx_s = 3'd0; end
      4'b0011: begin out_s = DIV_RE;  valid_s = 1'b1; idx_s = 3'd1; end
      4'b0101: begin out_s = DIV_MI;  valid_s = 1'b1; idx_s = 3'd2; end
      4'b1001: begin out_s = DIV_FA;  valid_s = 1'b1; idx_s = 3'd3; end
      4'b0111: begin out_s = DIV_SOL; valid_s = 1'b1; idx_s = 3'd4; end
      4'b1011: begin out_s = DIV_LA;  valid_s = 1'b1; idx_s = 3'd5; end
      4'b1101: begin out_s = DIV_SI;  valid_s = 1'b1; idx_s = 3'd6; end
      4'b1111: begin out_s = DIV_DO2; valid_s = 1'b1; idx_s = 3'd7; end
      default: begin
        out_s   = 32'd0;
        valid_s = 1'b0;
        idx_s   = 3'd0;
      end
    endcase
  end

  // Output registers, cleared asynchronously and reloaded every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r   <= 32'd0;
      valid_r <= 1'b0;
      idx_r   <= 3'd0;
    end else begin
      out_r   <= out_s;
      valid_r <= valid_s;
      idx_r   <= idx_s;
    end
  end

  assign out        = out_r;
  assign note_valid = valid_r;
  assign note_idx   = idx_r;

endmodule

// File: tb/tb_display_notes.sv
// Directed self-checking bench for display_notes; honours DISPLAY_NOTES_HALF_PERIOD_EN.
module tb_display_notes;

  logic        clk;
  logic        rst_n;
  logic [3:0]  sw;
  logic [31:0] out;
  logic        note_valid;
  logic [2:0]  note_idx;

  int n_checks;
  int n_errors;

`ifdef DISPLAY_NOTES_HALF_PERIOD_EN
  localparam int SH = 1;
`else
  localparam int SH = 0;
`endif

  // Hand-computed full-period counts, indexed by sw; 0 for illegal codes.
  logic [31:0] exp_out [16];
  logic        exp_vld [16];
  logic [2:0]  exp_idx [16];

  display_notes dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw         (sw),
    .out        (out),
    .note_valid (note_valid),
    .note_idx   (note_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_note(input string tag, input logic [3:0] code);
    check_val({tag, ".out"},   out, exp_out[code] >> SH);
    check_val({tag, ".valid"}, {31'd0, note_valid}, {31'd0, exp_vld[code]});
    check_val({tag, ".idx"},   {29'd0, note_idx}, {29'd0, exp_idx[code]});
  endtask

  // Drive a code at the falling edge, verify the old value holds, then the new one after the edge.
  task automatic apply(input string tag, input logic [3:0] code, input logic [3:0] prev);
    @(negedge clk);
    sw = code;
    #1;
    check_val({tag, ".hold"}, out, exp_out[prev] >> SH);
    @(posedge clk);
    #1;
    check_note(tag, code);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 16; i++) begin
      exp_out[i] = 32'd0;
      exp_vld[i] = 1'b0;
      exp_idx[i] = 3'd0;
    end
    exp_out[1]  = 32'd95602; exp_vld[1]  = 1'b1; exp_idx[1]  = 3'd0;
    exp_out[3]  = 32'd85178; exp_vld[3]  = 1'b1; exp_idx[3]  = 3'd1;
    exp_out[5]  = 32'd75872; exp_vld[5]  = 1'b1; exp_idx[5]  = 3'd2;
    exp_out[9]  = 32'd71633; exp_vld[9]  = 1'b1; exp_idx[9]  = 3'd3;
    exp_out[7]  = 32'd63856; exp_vld[7]  = 1'b1; exp_idx[7]  = 3'd4;
    exp_out[11] = 32'd56818; exp_vld[11] = 1'b1; exp_idx[11] = 3'd5;
    exp_out[13] = 32'd50658; exp_vld[13] = 1'b1; exp_idx[13] = 3'd6;
    exp_out[15] = 32'd47801; exp_vld[15] = 1'b1; exp_idx[15] = 3'd7;

    // Reset held with a legal code present, before any clock edge.
    rst_n = 1'b0;
    sw    = 4'b1111;
    #2;
    check_val("rst.out",   out, 32'd0);
    check_val("rst.valid", {31'd0, note_valid}, 32'd0);
    check_val("rst.idx",   {29'd0, note_idx}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rel.noedge", out, 32'd0);
    @(posedge clk);
    #1;
    check_note("rel.do2", 4'b1111);
    check_val("rel.do2.abs", out, 32'd47801 >> SH);

    apply("z0000", 4'b0000, 4'b1111);
    apply("do1",   4'b0001, 4'b0000);
    check_val("do1.abs", out, 32'd95602 >> SH);
    apply("re",    4'b0011, 4'b0001);
    apply("mi",    4'b0101, 4'b0011);
    apply("fa",    4'b1001, 4'b0101);
    apply("sol",   4'b0111, 4'b1001);
    apply("la",    4'b1011, 4'b0111);
    apply("si",    4'b1101, 4'b1011);

    // Stable input keeps the output constant.
    repeat (3) @(posedge clk);
    #1;
    check_note("si.stable", 4'b1101);

    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      sw = 4'(c);
      @(posedge clk);
      #1;
      check_note($sformatf("sweep%0d", c), 4'(c));
    end

    // Asynchronous reset mid-operation.
    @(negedge clk);
    sw = 4'b0001;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst.out",   out, 32'd0);
    check_val("midrst.valid", {31'd0, note_valid}, 32'd0);
    @(posedge clk);
    #1;
    check_val("midrst.held", out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_note("midrst.rel", 4'b0001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
